// File: rtl/debug_slave_jtag_master.sv
// JTAG initiator for the debug slave's virtual-JTAG port: one IR load plus one
// DR scan per command, returning the captured DR and the sampled ir_out.
module debug_slave_jtag_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DR_WIDTH-1:0] resp_dr,
    output logic [IR_WIDTH-1:0] resp_ir,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);
    localparam int PW = $clog2(2 * TCK_DIV);
    localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [PW-1:0] PH_RISE  = PW'(TCK_DIV - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(2 * TCK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);

    // S_LOAD is the one-clk gap between accept and the first tck-low UIR clk.
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       ph_q, ph_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [DR_WIDTH-1:0] dr_shift_q, dr_shift_d;
    logic [IR_WIDTH-1:0] resp_ir_q, resp_ir_d;
    logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
    logic                tck_q, tck_d, tdi_q, tdi_d;
    logic                uir_q, uir_d, cdr_q, cdr_d, sdr_q, sdr_d, udr_q, udr_d, rti_q, rti_d;
    logic                resp_valid_q, resp_valid_d, cmd_ready_q, cmd_ready_d;
    logic                active, tck_rise, boundary;

    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        bit_d        = bit_q;
        ir_d         = ir_q;
        dr_shift_d   = dr_shift_q;
        resp_ir_d    = resp_ir_q;
        ir_in_d      = ir_in_q;
        tck_d        = tck_q;
        tdi_d        = tdi_q;
        resp_valid_d = resp_valid_q;
        cmd_ready_d  = cmd_ready_q;

        active   = state_q inside {S_UIR, S_CDR, S_SDR, S_UDR, S_RTI};
        tck_rise = active && (ph_q == PH_RISE);
        boundary = active && (ph_q == PH_LAST);

        if (active) begin
            ph_d = boundary ? '0 : ph_q + PW'(1);
            if (tck_rise) tck_d = 1'b1;
            if (boundary) tck_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    ir_d        = cmd_ir;
                    dr_shift_d  = cmd_dr;
                    cmd_ready_d = 1'b0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_UIR;
                ph_d    = '0;
                tck_d   = 1'b0;
                tdi_d   = 1'b0;
                ir_in_d = ir_q;
            end
            S_UIR: begin
                if (tck_rise) resp_ir_d = vji_ir_out;
                if (boundary) state_d = S_CDR;
            end
            S_CDR: begin
                if (boundary) begin
                    state_d = S_SDR;
                    bit_d   = '0;
                    tdi_d   = dr_shift_q[0];
                end
            end
            S_SDR: begin
                // The rise always precedes the boundary, so bit 0 is already the next tdi.
                if (tck_rise) dr_shift_d = {vji_tdo, dr_shift_q[DR_WIDTH-1:1]};
                if (boundary) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = S_UDR;
                        tdi_d   = 1'b0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                        tdi_d = dr_shift_q[0];
                    end
                end
            end
            S_UDR: begin
                if (boundary) state_d = S_RTI;
            end
            S_RTI: begin
                if (boundary) begin
                    state_d      = S_DONE;
                    ir_in_d      = '0;
                    resp_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    cmd_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        uir_d = (state_d == S_UIR);
        cdr_d = (state_d == S_CDR);
        sdr_d = (state_d == S_SDR);
        udr_d = (state_d == S_UDR);
        rti_d = (state_d == S_RTI);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ph_q         <= '0;
            bit_q        <= '0;
            ir_q         <= '0;
            dr_shift_q   <= '0;
            resp_ir_q    <= '0;
            ir_in_q      <= '0;
            tck_q        <= 1'b0;
            tdi_q        <= 1'b0;
            uir_q        <= 1'b0;
            cdr_q        <= 1'b0;
            sdr_q        <= 1'b0;
            udr_q        <= 1'b0;
            rti_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            cmd_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            bit_q        <= bit_d;
            ir_q         <= ir_d;
            dr_shift_q   <= dr_shift_d;
            resp_ir_q    <= resp_ir_d;
            ir_in_q      <= ir_in_d;
            tck_q        <= tck_d;
            tdi_q        <= tdi_d;
            uir_q        <= uir_d;
            cdr_q        <= cdr_d;
            sdr_q        <= sdr_d;
            udr_q        <= udr_d;
            rti_q        <= rti_d;
            resp_valid_q <= resp_valid_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_dr    = dr_shift_q;
    assign resp_ir    = resp_ir_q;
    assign vji_tck    = tck_q;
    assign vji_tdi    = tdi_q;
    assign vji_ir_in  = ir_in_q;
    assign vji_uir    = uir_q;
    assign vji_cdr    = cdr_q;
    assign vji_sdr    = sdr_q;
    assign vji_udr    = udr_q;
    assign vji_rti    = rti_q;
endmodule

// File: tb/tb_debug_slave_jtag_master.sv
// Directed bench: two instances (TCK_DIV=2 and TCK_DIV=1), each with a 38-bit
// loopback shift register standing in for the debug slave's DR.
module tb_debug_slave_jtag_master;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // instance A: defaults
    logic        a_cmd_valid, a_cmd_ready, a_resp_valid, a_resp_ready;
    logic [1:0]  a_cmd_ir, a_resp_ir, a_ir_in, a_ir_out;
    logic [37:0] a_cmd_dr, a_resp_dr;
    logic        a_tck, a_tdi, a_tdo, a_uir, a_cdr, a_sdr, a_udr, a_rti;
    logic [4:0]  a_strb;
    logic [37:0] a_model, a_model_init;
    logic        a_model_ld = 1'b0;

    // instance B: TCK_DIV = 1
    logic        b_cmd_valid, b_cmd_ready, b_resp_valid, b_resp_ready;
    logic [1:0]  b_cmd_ir, b_resp_ir, b_ir_in, b_ir_out;
    logic [37:0] b_cmd_dr, b_resp_dr;
    logic        b_tck, b_tdi, b_tdo, b_uir, b_cdr, b_sdr, b_udr, b_rti;
    logic [4:0]  b_strb;
    logic [37:0] b_model, b_model_init;
    logic        b_model_ld = 1'b0;

    assign a_strb   = {a_uir, a_cdr, a_sdr, a_udr, a_rti};
    assign b_strb   = {b_uir, b_cdr, b_sdr, b_udr, b_rti};
    assign a_ir_out = a_uir ? 2'b01 : 2'b11;
    assign b_ir_out = b_uir ? 2'b01 : 2'b11;
    assign a_tdo    = a_model[0];
    assign b_tdo    = b_model[0];

    always @(posedge a_tck or posedge a_model_ld)
        if (a_model_ld) a_model <= a_model_init;
        else if (a_sdr) a_model <= {a_tdi, a_model[37:1]};

    always @(posedge b_tck or posedge b_model_ld)
        if (b_model_ld) b_model <= b_model_init;
        else if (b_sdr) b_model <= {b_tdi, b_model[37:1]};

    debug_slave_jtag_master dut_a (
        .clk(clk), .reset(reset),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_ir(a_cmd_ir), .cmd_dr(a_cmd_dr),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_dr(a_resp_dr), .resp_ir(a_resp_ir),
        .vji_tck(a_tck), .vji_tdi(a_tdi), .vji_tdo(a_tdo), .vji_ir_in(a_ir_in), .vji_ir_out(a_ir_out),
        .vji_uir(a_uir), .vji_cdr(a_cdr), .vji_sdr(a_sdr), .vji_udr(a_udr), .vji_rti(a_rti)
    );

    debug_slave_jtag_master #(.TCK_DIV(1)) dut_b (
        .clk(clk), .reset(reset),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_ir(b_cmd_ir), .cmd_dr(b_cmd_dr),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_dr(b_resp_dr), .resp_ir(b_resp_ir),
        .vji_tck(b_tck), .vji_tdi(b_tdi), .vji_tdo(b_tdo), .vji_ir_in(b_ir_in), .vji_ir_out(b_ir_out),
        .vji_uir(b_uir), .vji_cdr(b_cdr), .vji_sdr(b_sdr), .vji_udr(b_udr), .vji_rti(b_rti)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {uir,cdr,sdr,udr,rti} k clks after the accept edge.
    function automatic logic [4:0] exp_strb(input int k, input int div);
        int p = 2 * div;
        int idx;
        if (k < 1) return 5'b0;
        idx = (k - 1) / p;
        if (idx == 0) return 5'b10000;
        if (idx == 1) return 5'b01000;
        if (idx >= 2 && idx <= 39) return 5'b00100;
        if (idx == 40) return 5'b00010;
        if (idx == 41) return 5'b00001;
        return 5'b0;
    endfunction

    function automatic logic exp_tck(input int k, input int div);
        int p = 2 * div;
        if (k < 1 || (k - 1) / p >= 42) return 1'b0;
        return ((k - 1) % p) >= div;
    endfunction

    // Walks from the accept edge to the resp_valid edge, checking every clk.
    task automatic scan_walk(input bit use_b, input int div, input logic [1:0] ir);
        int last = 1 + 42 * 2 * div;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            chk($sformatf("strobes k=%0d", k), use_b ? b_strb : a_strb, exp_strb(k, div));
            chk($sformatf("tck k=%0d", k), use_b ? b_tck : a_tck, exp_tck(k, div));
            chk($sformatf("ir_in k=%0d", k), use_b ? b_ir_in : a_ir_in,
                (k >= 1 && k < last) ? ir : 2'b00);
            chk($sformatf("resp_valid k=%0d", k), use_b ? b_resp_valid : a_resp_valid, k == last);
            chk($sformatf("cmd_ready k=%0d", k), use_b ? b_cmd_ready : a_cmd_ready, 1'b0);
        end
    endtask

    task automatic a_issue(input logic [1:0] ir, input logic [37:0] dr);
        @(negedge clk);
        a_cmd_valid = 1'b1;
        a_cmd_ir    = ir;
        a_cmd_dr    = dr;
        @(posedge clk);
        #1 a_cmd_valid = 1'b0;
    endtask

    task automatic a_preload(input logic [37:0] v);
        a_model_init = v;
        a_model_ld   = 1'b1;
        #1 a_model_ld = 1'b0;
    endtask

    task automatic a_handshake(input string tag);
        @(negedge clk);
        a_resp_ready = 1'b1;
        @(negedge clk);
        a_resp_ready = 1'b0;
        chk({tag, " resp_valid cleared"}, a_resp_valid, 1'b0);
        chk({tag, " cmd_ready raised"}, a_cmd_ready, 1'b1);
    endtask

    initial begin
        bit seen_valid;
        reset        = 1'b1;
        a_cmd_valid  = 1'b1;
        a_cmd_ir     = 2'b10;
        a_cmd_dr     = 38'h3F_0000_FFFF;
        a_resp_ready = 1'b0;
        b_cmd_valid  = 1'b0;
        b_cmd_ir     = 2'b00;
        b_cmd_dr     = '0;
        b_resp_ready = 1'b0;
        #1 a_preload(38'h15_A5A5_A5A5);
        b_model_init = '0;
        b_model_ld   = 1'b1;
        #1 b_model_ld = 1'b0;

        // Reset held with cmd_valid high
        repeat (3) @(negedge clk);
        chk("rst outputs", {a_tck, a_tdi, a_ir_in, a_strb, a_resp_valid, a_resp_ir}, '0);
        chk("rst resp_dr", a_resp_dr, '0);
        chk("rst cmd_ready", a_cmd_ready, 1'b1);
        chk("rst b outputs", {b_tck, b_tdi, b_ir_in, b_strb, b_resp_valid, b_cmd_ready}, 12'h001);

        // Release: accepted on the first edge, then full loopback scan
        reset = 1'b0;
        @(posedge clk);
        #1 a_cmd_valid = 1'b0;
        scan_walk(1'b0, 2, 2'b10);
        chk("loop resp_dr", a_resp_dr, 38'h15_A5A5_A5A5);
        chk("loop model", a_model, 38'h3F_0000_FFFF);
        chk("loop resp_ir", a_resp_ir, 2'b01);

        // Response held: outputs stable, a new command is not taken
        a_cmd_valid = 1'b1;
        a_cmd_ir    = 2'b01;
        a_cmd_dr    = 38'h00_1234_5678;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("hold resp_valid %0d", i), a_resp_valid, 1'b1);
            chk($sformatf("hold resp_dr %0d", i), a_resp_dr, 38'h15_A5A5_A5A5);
            chk($sformatf("hold resp_ir %0d", i), a_resp_ir, 2'b01);
            chk($sformatf("hold busy %0d", i), {a_cmd_ready, a_strb, a_tck}, '0);
        end
        a_cmd_valid = 1'b0;
        a_handshake("hs1");

        // Reset in the middle of SDR
        a_preload(38'h00_0000_0000);
        a_issue(2'b11, 38'h2A_AAAA_AAAA);
        repeat (50) @(negedge clk);
        chk("mid sdr active", a_sdr, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst outputs", {a_tck, a_tdi, a_ir_in, a_strb, a_resp_valid}, '0);
        chk("midrst cmd_ready", a_cmd_ready, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a_resp_valid || a_strb != 5'b0) seen_valid = 1'b1;
        end
        chk("midrst no response", seen_valid, 1'b0);

        // New command after the aborted one
        a_preload(38'h2A_1234_5678);
        a_issue(2'b01, 38'h0F_DEAD_BEEF);
        scan_walk(1'b0, 2, 2'b01);
        chk("post resp_dr", a_resp_dr, 38'h2A_1234_5678);
        chk("post model", a_model, 38'h0F_DEAD_BEEF);
        chk("post resp_ir", a_resp_ir, 2'b01);
        a_handshake("hs2");

        // TCK_DIV = 1 loopback
        b_model_init = 38'h15_A5A5_A5A5;
        b_model_ld   = 1'b1;
        #1 b_model_ld = 1'b0;
        @(negedge clk);
        b_cmd_valid = 1'b1;
        b_cmd_ir    = 2'b10;
        b_cmd_dr    = 38'h3F_0000_FFFF;
        @(posedge clk);
        #1 b_cmd_valid = 1'b0;
        scan_walk(1'b1, 1, 2'b10);
        chk("div1 resp_dr", b_resp_dr, 38'h15_A5A5_A5A5);
        chk("div1 model", b_model, 38'h3F_0000_FFFF);
        chk("div1 resp_ir", b_resp_ir, 2'b01);
        @(negedge clk);
        b_resp_ready = 1'b1;
        @(negedge clk);
        b_resp_ready = 1'b0;
        chk("div1 cmd_ready", {b_cmd_ready, b_resp_valid}, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
